// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-network pipeline stages.
package nn_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_N_OUT  = 10;

  typedef logic signed [DEFAULT_DATA_W-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } argmax_state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Signed strict-greater compare with select: keeps ref_i unless the candidate wins or load_i forces it.
module argmax_cmp #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] cand_i,
  input  logic signed [DATA_W-1:0] ref_i,
  input  logic                     load_i,
  output logic                     take_o,
  output logic signed [DATA_W-1:0] sel_o
);

  // Strict compare: equal values keep the earlier (lower-index) holder.
  assign take_o = load_i || (cand_i > ref_i);
  assign sel_o  = take_o ? cand_i : ref_i;

endmodule

// File: rtl/output_argmax.sv
// Serial argmax over one output-layer vector, result held on a valid/ready port.
// Define OUTPUT_ARGMAX_MARGIN_EN to add out_margin (best minus second-best).
module output_argmax
  import nn_pkg::*;
#(
  parameter  int N_OUT  = DEFAULT_N_OUT,
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int CLS_W  = $clog2(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLS_W-1:0]         out_class,
  output logic signed [DATA_W-1:0] out_score,
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  output logic signed [DATA_W:0]   out_margin,
`endif
  output logic                     busy,
  output logic                     err
);

  localparam logic [CLS_W:0] LAST_BEAT = (CLS_W + 1)'(N_OUT - 1);

  argmax_state_e state_q, state_d;
  logic [CLS_W:0]          count_q, count_d;
  logic signed [DATA_W-1:0] best_q;
  logic [CLS_W-1:0]        idx_q;
  logic [CLS_W-1:0]        cls_q;
  logic signed [DATA_W-1:0] score_q;
  logic                    err_q, err_d;

  logic beat, first_beat, last_beat;
  logic take_best;
  logic signed [DATA_W-1:0] best_sel;

  assign beat       = in_valid && (state_q == COLLECT);
  assign first_beat = (count_q == '0);
  assign last_beat  = beat && (count_q == LAST_BEAT);

  argmax_cmp #(.DATA_W(DATA_W)) u_best_cmp (
    .cand_i (in_data),
    .ref_i  (best_q),
    .load_i (first_beat),
    .take_o (take_best),
    .sel_o  (best_sel)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = start && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      COLLECT: begin
        if (last_beat) begin
          state_d = HOLD;
        end else if (beat) begin
          count_d = count_q + (CLS_W + 1)'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Running best plus the registered result; the result is captured on the final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q  <= '0;
      idx_q   <= '0;
      cls_q   <= '0;
      score_q <= '0;
    end else if (beat) begin
      if (take_best) begin
        best_q <= best_sel;
        idx_q  <= count_q[CLS_W-1:0];
      end
      if (last_beat) begin
        cls_q   <= take_best ? count_q[CLS_W-1:0] : idx_q;
        score_q <= best_sel;
      end
    end
  end

`ifdef OUTPUT_ARGMAX_MARGIN_EN
  localparam logic signed [DATA_W-1:0] ACT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] second_q;
  logic signed [DATA_W:0]   margin_q;
  logic                     ge_best, take_second;
  logic signed [DATA_W-1:0] second_cand, second_sel;

  // A beat that displaces or ties the best pushes the old best down into second place.
  assign ge_best     = take_best || (in_data == best_q);
  assign second_cand = first_beat ? ACT_MIN : (ge_best ? best_q : in_data);

  argmax_cmp #(.DATA_W(DATA_W)) u_second_cmp (
    .cand_i (second_cand),
    .ref_i  (second_q),
    .load_i (ge_best),
    .take_o (take_second),
    .sel_o  (second_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      second_q <= '0;
      margin_q <= '0;
    end else if (beat) begin
      if (take_second) begin
        second_q <= second_sel;
      end
      if (last_beat) begin
        margin_q <= {best_sel[DATA_W-1], best_sel} - {second_sel[DATA_W-1], second_sel};
      end
    end
  end

  assign out_margin = margin_q;
`endif

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_class = cls_q;
  assign out_score = score_q;
  assign err       = err_q;

endmodule

// File: tb/tb_output_argmax.sv
// Randomized scoreboard bench for output_argmax (N_OUT=4, DATA_W=8).
module tb_output_argmax;

  localparam int N_OUT  = 4;
  localparam int DATA_W = 8;
  localparam int CLS_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, busy, err;
  logic [CLS_W-1:0] out_class;
  logic signed [DATA_W-1:0] out_score;
`ifdef OUTPUT_ARGMAX_MARGIN_EN
  logic signed [DATA_W:0] out_margin;
`endif

  output_argmax #(.N_OUT(N_OUT), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
`ifdef OUTPUT_ARGMAX_MARGIN_EN
    .out_margin(out_margin),
`endif
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int score;
    int margin;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int txn = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: first index of the maximum; margin is top minus runner-up of the sorted vector.
  function automatic exp_t model(input int v[N_OUT]);
    exp_t e;
    int s[$];
    int mx;
    mx = v[0];
    for (int i = 1; i < N_OUT; i++) if (v[i] > mx) mx = v[i];
    e.cls = -1;
    for (int i = 0; i < N_OUT; i++) if (v[i] == mx && e.cls < 0) e.cls = i;
    e.score = mx;
    for (int i = 0; i < N_OUT; i++) s.push_back(v[i]);
    s.sort();
    e.margin = s[N_OUT-1] - s[N_OUT-2];
    return e;
  endfunction

  // Monitor: every accepted result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got class %0d with empty scoreboard", out_class);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_class", int'(out_class), mon_e.cls);
        chk("out_score", int'(out_score), mon_e.score);
`ifdef OUTPUT_ARGMAX_MARGIN_EN
        chk("out_margin", int'(out_margin), mon_e.margin);
`endif
        $display("txn %0d: class=%0d score=%0d (exp class=%0d score=%0d)",
                 txn, out_class, out_score, mon_e.cls, mon_e.score);
        txn++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beats(input int v[N_OUT], input int n, input int max_gap);
    logic acc;
    int waits;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = 8'(v[k]);
      waits = 0;
      forever begin
        @(negedge clk);
        acc = in_ready;
        tick();
        if (acc) break;
        waits++;
        if (waits > 20) begin
          chk("beat_accept_timeout", 0, 1);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Hold the result for hold cycles, then handshake (optionally with a colliding start).
  task automatic finish_result(input exp_t e, input int hold, input bit start_on_hs);
    @(negedge clk);
    chk("latency_out_valid", int'(out_valid), 1);
    @(posedge clk);
    #1;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_class", int'(out_class), e.cls);
      chk("hold_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    start = start_on_hs;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_hs_valid", int'(out_valid), 0);
    chk("post_hs_busy", int'(busy), 0);
    chk("post_hs_err", int'(err), int'(start_on_hs));
    @(posedge clk);
    #1;
  endtask

  task automatic run_vector(input int v[N_OUT], input int max_gap, input int hold, input bit start_on_hs);
    exp_t e;
    e = model(v);
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    sb_q.push_back(e);
    send_start();
    send_beats(v, N_OUT, max_gap);
    finish_result(e, hold, start_on_hs);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[N_OUT];
    exp_t e;

    tick();
    tick();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_class", int'(out_class), 0);
    chk("rst_score", int'(out_score), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    run_vector('{3, -5, 20, 7}, 0, 0, 1'b0);
    run_vector('{9, 9, -1, 9}, 0, 1, 1'b0);
    run_vector('{-128, -128, -127, -128}, 0, 0, 1'b0);

    // Stalled consumer with a stray start while holding.
    v = '{1, 5, 2, 0};
    e = model(v);
    sb_q.push_back(e);
    send_start();
    send_beats(v, N_OUT, 0);
    for (int c = 0; c < 6; c++) begin
      start = (c == 1);
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_busy", int'(busy), 1);
      chk("stall_class", int'(out_class), e.cls);
      chk("stall_score", int'(out_score), e.score);
      chk("stall_err", int'(err), int'(c == 2));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("hs_start_err", int'(err), 1);
    chk("hs_start_not_queued", int'(busy), 0);
    @(posedge clk);
    #1;

    run_vector('{-3, 4, 4, -9}, 3, 2, 1'b0);

    // Reset in the middle of a collection.
    send_start();
    send_beats('{50, 60, 0, 0}, 2, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_class", int'(out_class), 0);
    chk("mid_rst_score", int'(out_score), 0);
    tick();
    rst = 1'b1;
    tick();
    run_vector('{1, 2, 3, 4}, 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (t % 2 == 0) v[i] = int'($signed(8'($urandom_range(255, 0))));
        else v[i] = int'($urandom_range(7, 0)) - 4;
      end
      run_vector(v, $urandom_range(2, 0), $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
